// File: rtl/mac_accumulator.sv
// Accumulates N_TERMS signed Q1.15 products plus a Q1.7 bias, then rounds and
// saturates the sum to one Q1.7 word presented on a valid/ready output.
module mac_accumulator #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] product,
    input  logic [7:0]  bias,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_sat
);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;
    localparam logic [7:0] LAST_CNT = 8'(N_TERMS - 1);

    localparam logic signed [ACC_W:0] RND   = 128;
    localparam logic signed [ACC_W:0] R_MAX = 127;
    localparam logic signed [ACC_W:0] R_MIN = -128;

    logic [0:0]              state_reg;
    logic [7:0]              cnt_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] product_ext;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W:0]   sum_wide;
    logic signed [ACC_W:0]   rnd_wide;
    logic [7:0]              data_next;
    logic                    sat_next;
    logic                    out_valid_reg;
    logic [7:0]              out_data_reg;
    logic                    out_sat_reg;
    logic                    take;

    // in_ready depends only on state (and reset), never on in_valid.
    assign in_ready  = !rst && (state_reg == ST_ACCUM);
    assign take      = in_valid && in_ready;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sat   = out_sat_reg;

    assign product_ext = {{(ACC_W-16){product[15]}}, product};
    assign bias_ext    = {{(ACC_W-16){bias[7]}}, bias, 8'h00};

    // The first term of a result starts from the bias instead of the old sum,
    // which also covers N_TERMS==1 (bias + product finalizes directly).
    always_comb begin
        acc_base = (cnt_reg == 8'd0) ? bias_ext : acc_reg;
        acc_next = acc_base + product_ext;
        sum_wide = {acc_next[ACC_W-1], acc_next};
        rnd_wide = (sum_wide + RND) >>> 8;
        data_next = rnd_wide[7:0];
        sat_next  = 1'b0;
        if (rnd_wide > R_MAX) begin
            data_next = 8'h7F;
            sat_next  = 1'b1;
        end else if (rnd_wide < R_MIN) begin
            data_next = 8'h80;
            sat_next  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_ACCUM;
            cnt_reg       <= 8'd0;
            acc_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= 8'h00;
            out_sat_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_ACCUM: begin
                    if (take) begin
                        acc_reg <= acc_next;
                        if (cnt_reg == LAST_CNT) begin
                            cnt_reg       <= 8'd0;
                            out_data_reg  <= data_next;
                            out_sat_reg   <= sat_next;
                            out_valid_reg <= 1'b1;
                            state_reg     <= ST_HOLD;
                        end else begin
                            cnt_reg <= cnt_reg + 8'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    // Result is held stable; out_data/out_sat keep their value after the transfer.
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ST_ACCUM;
                    end
                end
                default: state_reg <= ST_ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed self-checking bench for mac_accumulator with N_TERMS=4.
module tb_mac_accumulator;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] product;
    logic [7:0]  bias;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_sat;

    int checks;
    int failures;

    mac_accumulator #(.N_TERMS(4), .ACC_W(24)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .product   (product),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents four terms back to back; bias is meaningful on the first only.
    task automatic feed4(input logic [7:0] b, input logic [15:0] p0, input logic [15:0] p1,
                         input logic [15:0] p2, input logic [15:0] p3);
        logic [15:0] ps [4];
        ps[0] = p0; ps[1] = p1; ps[2] = p2; ps[3] = p3;
        for (int i = 0; i < 4; i++) begin
            int t;
            t = 0;
            while (!in_ready && t < 20) begin
                tick();
                t++;
            end
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL feed_in_ready_timeout term=%0d got=%b want=1", i, in_ready);
            end
            in_valid = 1'b1;
            bias     = b;
            product  = ps[i];
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; bias = 8'h55; product = 16'h1234; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 || out_sat !== 1'b0) begin
                failures++;
                $display("FAIL reset_state cyc=%0d got in_ready=%b out_valid=%b out_data=%h out_sat=%b want 0,0,00,0",
                         i, in_ready, out_valid, out_data, out_sat);
            end
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_in_ready got=%b want=1", in_ready);
        end
        $display("test_reset done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_nominal();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; bias = 8'h10; product = 16'h1000;
            tick();
            if (i < 3) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL nominal_early_valid term=%0d got=%b want=0", i, out_valid);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h50 || out_sat !== 1'b0) begin
            failures++;
            $display("FAIL nominal_result got valid=%b data=%h sat=%b want 1,50,0", out_valid, out_data, out_sat);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h50) begin
            failures++;
            $display("FAIL nominal_after_xfer got valid=%b in_ready=%b data=%h want 0,1,50", out_valid, in_ready, out_data);
        end
        $display("test_nominal done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_saturation();
        logic [7:0]  bv [2];
        logic [15:0] pv [2];
        logic [7:0]  dv [2];
        bv[0] = 8'h7F; pv[0] = 16'h7FFF; dv[0] = 8'h7F;
        bv[1] = 8'h80; pv[1] = 16'h8000; dv[1] = 8'h80;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            feed4(bv[k], pv[k], pv[k], pv[k], pv[k]);
            checks++;
            if (out_valid !== 1'b1 || out_data !== dv[k] || out_sat !== 1'b1) begin
                failures++;
                $display("FAIL saturation vec=%0d got valid=%b data=%h sat=%b want 1,%h,1",
                         k, out_valid, out_data, out_sat, dv[k]);
            end
            tick();
        end
        $display("test_saturation done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_rounding();
        logic [15:0] pv [3];
        logic [7:0]  dv [3];
        pv[0] = 16'h0080; dv[0] = 8'h01;
        pv[1] = 16'hFF80; dv[1] = 8'h00;
        pv[2] = 16'hFF7F; dv[2] = 8'hFF;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            feed4(8'h00, pv[k], 16'h0000, 16'h0000, 16'h0000);
            checks++;
            if (out_valid !== 1'b1 || out_data !== dv[k] || out_sat !== 1'b0) begin
                failures++;
                $display("FAIL rounding vec=%0d got valid=%b data=%h sat=%b want 1,%h,0",
                         k, out_valid, out_data, out_sat, dv[k]);
            end
            tick();
        end
        $display("test_rounding done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        feed4(8'h10, 16'h1000, 16'h1000, 16'h1000, 16'h1000);
        in_valid = 1'b1; bias = 8'h00; product = 16'h0100;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h50) begin
                failures++;
                $display("FAIL backpressure_hold cyc=%0d got in_ready=%b valid=%b data=%h want 0,1,50",
                         i, in_ready, out_valid, out_data);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_release got in_ready=%b valid=%b want 1,0", in_ready, out_valid);
        end
        for (int i = 0; i < 4; i++) tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h04 || out_sat !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_result got valid=%b data=%h sat=%b want 1,04,0", out_valid, out_data, out_sat);
        end
        tick();
        $display("test_back_to_back done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; bias = 8'h7F; product = 16'h7FFF;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 || out_sat !== 1'b0) begin
            failures++;
            $display("FAIL midreset_state got in_ready=%b valid=%b data=%h sat=%b want 0,0,00,0",
                     in_ready, out_valid, out_data, out_sat);
        end
        rst = 1'b0;
        feed4(8'h08, 16'h0800, 16'h0800, 16'h0800, 16'h0800);
        // 8/128 bias + 4 * 2048/32768 = 40/128
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h28 || out_sat !== 1'b0) begin
            failures++;
            $display("FAIL midreset_result got valid=%b data=%h sat=%b want 1,28,0", out_valid, out_data, out_sat);
        end
        tick();
        $display("test_mid_reset done checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; in_valid = 1'b0; product = 16'h0000; bias = 8'h00; out_ready = 1'b0;
        test_reset();
        test_nominal();
        test_saturation();
        test_rounding();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
